// File: rtl/soc_node_err_slv_if.sv
// AXI4 subset seen by the soc_node error responder: handshakes, IDs, lengths and response fields.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both 1; a sender holds its payload stable while valid=1 and ready=0, and ready never depends combinationally on valid.
interface soc_node_err_slv_if #(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6
);
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [7:0]            aw_len;
  logic                  w_valid;
  logic                  w_ready;
  logic                  w_last;
  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic [USER_WIDTH-1:0] b_user;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [7:0]            ar_len;
  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;

  modport master (
    output aw_valid, aw_id, aw_len, w_valid, w_last, b_ready, ar_valid, ar_id, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
           ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
  );

  modport slave (
    input  aw_valid, aw_id, aw_len, w_valid, w_last, b_ready, ar_valid, ar_id, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, b_user,
           ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
  );
endinterface

// File: rtl/soc_node_err_slv.sv
// Terminating AXI4 responder: accepts every write and read on an unmapped leg and answers with an error.
// Write and read channels are independent FSMs, one outstanding transaction each; idle states encode as 0.
module soc_node_err_slv #(
  parameter int          AXI_ID_WIDTH   = 6,
  parameter int          AXI_DATA_WIDTH = 64,
  parameter int          AXI_USER_WIDTH = 6,
  parameter logic [1:0]  RESP           = 2'b11,
  parameter logic [63:0] RDATA          = 64'hBADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  soc_node_err_slv_if.slave    axi,
  output logic [1:0]           w_state_dbg,
  output logic                 r_state_dbg
);

  localparam logic [AXI_DATA_WIDTH-1:0] RDATA_EXT = AXI_DATA_WIDTH'(RDATA);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e                w_state, w_next;
  r_state_e                r_state, r_next;
  logic [AXI_ID_WIDTH-1:0] aw_id_q;
  logic [AXI_ID_WIDTH-1:0] ar_id_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    beat_last;

  // ---------------- write channel ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      aw_id_q <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && axi.aw_valid) aw_id_q <= axi.aw_id;
    end
  end

  // Burst end is taken from w_last alone; aw_len is deliberately not tracked.
  always_comb begin
    w_next       = w_state;
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi.aw_ready = 1'b1;
        if (axi.aw_valid) w_next = W_DATA;
      end
      W_DATA: begin
        axi.w_ready = 1'b1;
        if (axi.w_valid && axi.w_last) w_next = W_RESP;
      end
      W_RESP: begin
        axi.b_valid = 1'b1;
        if (axi.b_ready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign axi.b_id   = aw_id_q;
  assign axi.b_resp = axi.b_valid ? RESP : 2'b00;
  assign axi.b_user = '0;

  // ---------------- read channel ----------------
  // Beat count is compared before it increments, so len=255 gives 256 beats without wrapping.
  assign beat_last = (cnt_q == len_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      ar_id_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && axi.ar_valid) begin
        ar_id_q <= axi.ar_id;
        len_q   <= axi.ar_len;
        cnt_q   <= '0;
      end else if (r_state == R_DATA && axi.r_ready && !beat_last) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    r_next       = r_state;
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.r_last   = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi.ar_ready = 1'b1;
        if (axi.ar_valid) r_next = R_DATA;
      end
      R_DATA: begin
        axi.r_valid = 1'b1;
        axi.r_last  = beat_last;
        if (axi.r_ready && beat_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign axi.r_id   = ar_id_q;
  assign axi.r_data = axi.r_valid ? RDATA_EXT : '0;
  assign axi.r_resp = axi.r_valid ? RESP : 2'b00;
  assign axi.r_user = '0;

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

endmodule

// File: tb/tb_soc_node_err_slv.sv
// Bench for soc_node_err_slv: directed scenarios plus random traffic, checked against a
// transaction-level model (pending-B queue and expected-R-beat queue).
module tb_soc_node_err_slv;
  localparam int IDW = 6;
  localparam int DW  = 64;
  localparam int UW  = 6;
  localparam logic [63:0] EXP_RDATA = 64'hBADC_AB1E;

  logic       clk_i;
  logic       rst_ni;
  logic [1:0] w_state_dbg;
  logic       r_state_dbg;

  soc_node_err_slv_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) axi ();

  soc_node_err_slv #(
    .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .axi         (axi),
    .w_state_dbg (w_state_dbg),
    .r_state_dbg (r_state_dbg)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [IDW-1:0] exp_b_q[$];   // B responses owed, in order
  logic [IDW:0]   exp_r_q[$];   // {last, id} per R beat still owed
  logic           w_open;       // address accepted, still sinking data
  logic [IDW-1:0] w_open_id;
  int             b_done;       // B handshakes seen
  int             r_beats;      // R handshakes seen
  int             r_lasts;      // R handshakes with r_last

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_b_q.delete();
    exp_r_q.delete();
    w_open    = 1'b0;
    w_open_id = '0;
  endtask

  // Called at a falling edge with inputs already driven: checks outputs, advances the
  // model by the handshakes the coming rising edge performs, then moves to the next falling edge.
  task automatic step();
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [IDW:0] front;
    check("aw_ready", 64'(axi.aw_ready), 64'(!w_open && exp_b_q.size() == 0));
    check("w_ready",  64'(axi.w_ready),  64'(w_open));
    check("b_valid",  64'(axi.b_valid),  64'(exp_b_q.size() != 0));
    check("b_user",   64'(axi.b_user),   64'(0));
    if (exp_b_q.size() != 0) begin
      check("b_id",   64'(axi.b_id),   64'(exp_b_q[0]));
      check("b_resp", 64'(axi.b_resp), 64'(2'b11));
    end
    check("ar_ready", 64'(axi.ar_ready), 64'(exp_r_q.size() == 0));
    check("r_valid",  64'(axi.r_valid),  64'(exp_r_q.size() != 0));
    check("r_user",   64'(axi.r_user),   64'(0));
    if (exp_r_q.size() != 0) begin
      front = exp_r_q[0];
      check("r_id",   64'(axi.r_id),   64'(front[IDW-1:0]));
      check("r_last", 64'(axi.r_last), 64'(front[IDW]));
      check("r_data", 64'(axi.r_data), EXP_RDATA);
      check("r_resp", 64'(axi.r_resp), 64'(2'b11));
    end
    if (!rst_ni) begin
      model_clear();
    end else begin
      aw_hs = axi.aw_valid && !w_open && exp_b_q.size() == 0;
      w_hs  = axi.w_valid && w_open;
      b_hs  = axi.b_ready && exp_b_q.size() != 0;
      ar_hs = axi.ar_valid && exp_r_q.size() == 0;
      r_hs  = axi.r_ready && exp_r_q.size() != 0;
      if (b_hs) begin
        void'(exp_b_q.pop_front());
        b_done++;
      end
      if (w_hs && axi.w_last) begin
        exp_b_q.push_back(w_open_id);
        w_open = 1'b0;
      end
      if (aw_hs) begin
        w_open    = 1'b1;
        w_open_id = axi.aw_id;
      end
      if (r_hs) begin
        front = exp_r_q.pop_front();
        r_beats++;
        if (front[IDW]) r_lasts++;
      end
      if (ar_hs) begin
        for (int i = 0; i <= int'(axi.ar_len); i++)
          exp_r_q.push_back({(i == int'(axi.ar_len)), axi.ar_id});
      end
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    axi.aw_valid = 1'b0; axi.aw_id = '0; axi.aw_len = '0;
    axi.w_valid  = 1'b0; axi.w_last = 1'b0; axi.b_ready = 1'b0;
    axi.ar_valid = 1'b0; axi.ar_id = '0; axi.ar_len = '0;
    axi.r_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    check("w_dbg_idle", 64'(w_state_dbg), 64'(0));
    check("r_dbg_idle", 64'(r_state_dbg), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  int b0, r0, l0;

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    model_clear();
    b_done = 0; r_beats = 0; r_lasts = 0;
    @(negedge clk_i);
    do_reset();
    step();

    // 1: single-beat write, B two cycles after AW
    b0 = b_done;
    axi.aw_valid = 1'b1; axi.aw_id = 6'h05; axi.aw_len = 8'd0;
    step();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b1; axi.w_last = 1'b1; axi.b_ready = 1'b1;
    step();
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
    check("t1_b_valid", 64'(axi.b_valid), 64'(1));
    check("t1_b_id",    64'(axi.b_id),    64'(6'h05));
    step();
    axi.b_ready = 1'b0;
    step();
    check("t1_b_count", 64'(b_done - b0), 64'(1));

    // 2: four W beats with gaps, then B stalled 3 cycles
    b0 = b_done;
    axi.aw_valid = 1'b1; axi.aw_id = 6'h17; axi.aw_len = 8'd3;
    step();
    axi.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi.w_valid = 1'b1; axi.w_last = (i == 3);
      step();
      axi.w_valid = 1'b0; axi.w_last = 1'b0;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("t2_aw_ready_stall", 64'(axi.aw_ready), 64'(0));
      step();
    end
    axi.b_ready = 1'b1;
    step();
    axi.b_ready = 1'b0;
    step();
    check("t2_b_count", 64'(b_done - b0), 64'(1));

    // 3: 4-beat read with toggling r_ready
    r0 = r_beats; l0 = r_lasts;
    axi.ar_valid = 1'b1; axi.ar_id = 6'h2A; axi.ar_len = 8'd3;
    step();
    axi.ar_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      axi.r_ready = i[0];
      step();
    end
    axi.r_ready = 1'b0;
    check("t3_beats", 64'(r_beats - r0), 64'(4));
    check("t3_lasts", 64'(r_lasts - l0), 64'(1));

    // 4: 256-beat read
    r0 = r_beats; l0 = r_lasts;
    axi.ar_valid = 1'b1; axi.ar_id = 6'h11; axi.ar_len = 8'd255;
    step();
    axi.ar_valid = 1'b0; axi.r_ready = 1'b1;
    for (int i = 0; i < 258; i++) step();
    axi.r_ready = 1'b0;
    check("t4_beats", 64'(r_beats - r0), 64'(256));
    check("t4_lasts", 64'(r_lasts - l0), 64'(1));
    check("t4_ar_ready", 64'(axi.ar_ready), 64'(1));

    // 5: AW and AR in the same cycle
    b0 = b_done; r0 = r_beats;
    axi.aw_valid = 1'b1; axi.aw_id = 6'h01; axi.aw_len = 8'd0;
    axi.ar_valid = 1'b1; axi.ar_id = 6'h02; axi.ar_len = 8'd1;
    check("t5_aw_ready", 64'(axi.aw_ready), 64'(1));
    check("t5_ar_ready", 64'(axi.ar_ready), 64'(1));
    step();
    idle_inputs();
    axi.w_valid = 1'b1; axi.w_last = 1'b1; axi.b_ready = 1'b1; axi.r_ready = 1'b1;
    step();
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
    for (int i = 0; i < 4; i++) step();
    idle_inputs();
    check("t5_b_count", 64'(b_done - b0), 64'(1));
    check("t5_r_beats", 64'(r_beats - r0), 64'(2));

    // 6: reset mid-read and in the response phase of a write
    r0 = r_beats;
    axi.ar_valid = 1'b1; axi.ar_id = 6'h33; axi.ar_len = 8'd3;
    step();
    axi.ar_valid = 1'b0; axi.r_ready = 1'b1;
    step();
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("t6_r_valid_after_rst", 64'(axi.r_valid), 64'(0));
    for (int i = 0; i < 4; i++) step();
    axi.r_ready = 1'b0;
    check("t6_r_beats", 64'(r_beats - r0), 64'(2));
    b0 = b_done;
    axi.aw_valid = 1'b1; axi.aw_id = 6'h3C; axi.aw_len = 8'd0;
    step();
    axi.aw_valid = 1'b0; axi.w_valid = 1'b1; axi.w_last = 1'b1;
    step();
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
    check("t6_b_pending", 64'(axi.b_valid), 64'(1));
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    axi.b_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    axi.b_ready = 1'b0;
    check("t6_no_b", 64'(b_done - b0), 64'(0));

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      axi.aw_valid = ($urandom_range(0, 3) == 0);
      axi.aw_id    = IDW'($urandom);
      axi.aw_len   = 8'($urandom_range(0, 7));
      axi.w_valid  = $urandom_range(0, 1) == 1;
      axi.w_last   = ($urandom_range(0, 2) == 0);
      axi.b_ready  = $urandom_range(0, 1) == 1;
      axi.ar_valid = ($urandom_range(0, 3) == 0);
      axi.ar_id    = IDW'($urandom);
      axi.ar_len   = 8'($urandom_range(0, 5));
      axi.r_ready  = $urandom_range(0, 1) == 1;
      rst_ni       = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_ni = 1'b1;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
